branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32: branch target / PC width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: bubble cycles after the redirect cycle; legal range 1..15.
REQ-003 SHALL have parameters EQ=0, GT=1, AL=2, NE=3: condition-code encodings.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port br_valid_i  in  1  branch instruction present in execute.
REQ-007 SHALL have port br_cond_i  in  2  condition code of the branch.
REQ-008 SHALL have port br_target_i  in  PC_W  branch target address.
REQ-009 SHALL have port flags_we_i  in  1  flag-setting ALU operation completes this cycle.
REQ-010 SHALL have port alu_zero_i  in  1  ALU result zero.
REQ-011 SHALL have port alu_gt_i  in  1  ALU compare greater-than.
REQ-012 SHALL have port stall_i  in  1  pipeline hold from downstream.
REQ-013 SHALL have port br_ready_o  out  1  controller can accept a branch.
REQ-014 SHALL have port pc_sel_o  out  1  select pc_target_o as next PC.
REQ-015 SHALL have port pc_target_o  out  PC_W  registered taken-branch target.
REQ-016 SHALL have port flush_o  out  1  kill the younger instructions in fetch/decode.
REQ-017 SHALL have port flags_o  out  2  flag register {gt, zero}.
REQ-018 SHALL have port taken_cnt_o  out  16  count of taken branches, saturating.

Function
REQ-019 SHALL implement FSM states IDLE, REDIRECT, FLUSH.
REQ-020 br_ready_o SHALL equal (state==IDLE) & ~stall_i; a branch is accepted on an edge where br_valid_i & br_ready_o.
REQ-021 Condition evaluation SHALL be: EQ -> zero==1; GT -> gt==1; AL -> always 1; NE -> zero==0.
REQ-022 Accepted and taken: next state REDIRECT, pc_target_o <= br_target_i, taken_cnt_o increments, saturating at 0xFFFF.
REQ-023 Accepted and not taken: state stays IDLE; no output changes except flags.
REQ-024 REDIRECT SHALL drive pc_sel_o=1 and flush_o=1 for one cycle, then go to FLUSH with the bubble counter at FLUSH_CYCLES; under stall_i the state SHALL hold REDIRECT with both outputs still high.
REQ-025 FLUSH SHALL drive flush_o=1 and pc_sel_o=0, decrement the counter on each unstalled edge, and return to IDLE on the edge where the counter reaches 1.
REQ-026 Latency: a branch accepted at edge N SHALL give pc_sel_o=1 in cycle N+1 and flush_o=1 in cycles N+1..N+1+FLUSH_CYCLES when unstalled.
REQ-027 The flag register SHALL load {alu_gt_i, alu_zero_i} on an edge with flags_we_i=1 and flush_o=0; flag writes while flush_o=1 SHALL be ignored.
REQ-028 br_valid_i while br_ready_o=0 SHALL be ignored; the instruction source holds it until accepted.
REQ-029 pc_target_o SHALL hold its value until the next taken branch.

Reset
REQ-030 rst_i=1 at an edge SHALL force state IDLE, counter 0, flags_o=2'b00, pc_target_o=0, taken_cnt_o=0, pc_sel_o=0, flush_o=0.
REQ-031 Reset asserted in REDIRECT or FLUSH SHALL abort the sequence; pc_sel_o and flush_o SHALL be 0 in the cycle after that edge.
REQ-032 br_ready_o SHALL be 1 in the first cycle after reset is released, unless stall_i=1.

Configuration
REQ-033 With macro BRANCH_CTRL_FLAG_BYPASS_EN defined, a branch accepted on the same edge as an effective flag write SHALL evaluate using {alu_gt_i, alu_zero_i}.
REQ-034 Without BRANCH_CTRL_FLAG_BYPASS_EN, evaluation SHALL always use the registered flags_o; in that case the source inserts one cycle between a flag write and a dependent branch.

Verification
REQ-035 Reset; write zero=1, gt=0; EQ branch to 0x100 -> pc_sel_o=1 one cycle with pc_target_o=0x100, flush_o high 3 cycles, taken_cnt_o=1.
REQ-036 Flags {gt=0,zero=0}; GT branch -> not taken, pc_sel_o stays 0, br_ready_o stays 1, taken_cnt_o unchanged.
REQ-037 AL branch accepted, stall_i high for 2 cycles in REDIRECT -> pc_sel_o high 3 cycles, then FLUSH lasts 2 unstalled cycles.
REQ-038 flags_we_i with zero=1 during FLUSH -> flags_o unchanged; an NE branch afterwards is taken.
REQ-039 Same-edge flag write zero=1 with an EQ branch and flags_o=00 -> taken if BRANCH_CTRL_FLAG_BYPASS_EN is defined, not taken otherwise.
REQ-040 rst_i pulsed in FLUSH -> next cycle flush_o=0, flags_o=00, taken_cnt_o=0, br_ready_o=1; preload taken_cnt_o to 0xFFFF and take a branch -> stays 0xFFFF.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves branches in execute, redirects the PC, flushes younger slots.
// Optional macro BRANCH_CTRL_FLAG_BYPASS_EN: same-edge flag write feeds evaluation.
module branch_ctrl #(
  parameter int         PC_W         = 32,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] EQ           = 2'd0,
  parameter logic [1:0] GT           = 2'd1,
  parameter logic [1:0] AL           = 2'd2,
  parameter logic [1:0] NE           = 2'd3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            br_valid_i,
  input  logic [1:0]      br_cond_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            flags_we_i,
  input  logic            alu_zero_i,
  input  logic            alu_gt_i,
  input  logic            stall_i,
  output logic            br_ready_o,
  output logic            pc_sel_o,
  output logic [PC_W-1:0] pc_target_o,
  output logic            flush_o,
  output logic [1:0]      flags_o,
  output logic [15:0]     taken_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       flag_wr;
  logic       taken;
  logic [1:0] eval_flags;

  assign br_ready_o = (state_q == IDLE) & ~stall_i;
  assign pc_sel_o   = (state_q == REDIRECT);
  assign flush_o    = (state_q != IDLE);
  assign accept     = br_valid_i & br_ready_o;
  assign flag_wr    = flags_we_i & ~flush_o;

`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
  assign eval_flags = flag_wr ? {alu_gt_i, alu_zero_i} : flags_o;
`else
  assign eval_flags = flags_o;
`endif

  // eval_flags = {gt, zero}
  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (br_cond_i == EQ): taken = eval_flags[0];
      (br_cond_i == GT): taken = eval_flags[1];
      (br_cond_i == AL): taken = 1'b1;
      (br_cond_i == NE): taken = ~eval_flags[0];
      default:           taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && taken) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (!stall_i) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      flags_o     <= 2'b00;
      pc_target_o <= '0;
      taken_cnt_o <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flag_wr) flags_o <= {alu_gt_i, alu_zero_i};
      if (accept && taken) begin
        pc_target_o <= br_target_i;
        taken_cnt_o <= (taken_cnt_o == 16'hFFFF) ?
                       taken_cnt_o : taken_cnt_o + 16'd1;
      end
    end
  end

endmodule
